// File: rtl/snn_wb_pkg.sv
// Shared types and constants for the neuron parameter loader.
// Holds the default address map, the queued command layout, the
// loader FSM encoding and the parameter address helper.
package snn_wb_pkg;

  // Default base of the core's parameter region and per-neuron window size.
  localparam logic [31:0] PARAM_BASE    = 32'h8002_0000;
  localparam logic [31:0] NEURON_STRIDE = 32'h0000_0100;

  // One queued host command: a single parameter word access.
  typedef struct packed {
    logic        we;
    logic [7:0]  neuron;
    logic [5:0]  word;
    logic [3:0]  sel;
    logic [31:0] data;
  } param_cmd_t;

  // Loader sequencing: wait for work, run one bus cycle, hand back a response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } loader_state_t;

  // Byte address of a parameter word; all terms wrap modulo 2^32.
  function automatic logic [31:0] param_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [7:0]  neuron,
                                             input logic [5:0]  word);
    logic [31:0] prod;
    prod = 32'(neuron) * stride;
    return base + prod + {24'd0, word, 2'b00};
  endfunction

endpackage

// File: rtl/snn_param_loader_if.sv
// Wishbone classic single-master bus between the loader and the core's
// parameter responder. Signal names keep the master's point of view.
//
// Handshake: the master holds cyc/stb with stable adr/dat/sel/we until the
// responder raises ack for one sampled edge; ack while cyc is low carries no
// meaning and is ignored by the master.
interface snn_param_loader_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i
  );
endinterface

// File: rtl/snn_cmd_fifo.sv
// Strict in-order command FIFO. Flags come from a registered occupancy
// count, so a full FIFO refuses a push even when a pop happens on the same
// edge. Data written on an edge is visible at the head one cycle later.
module snn_cmd_fifo
  import snn_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  param_cmd_t    din,
  input  logic          pop,
  output param_cmd_t    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  param_cmd_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage array: written only on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; reset flushes the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/snn_param_loader.sv
// Wishbone initiator that turns queued host commands into single-beat
// parameter accesses on a 256-neuron core. One command is in flight at a
// time; each ends in exactly one response (ack data or timeout abort).
// No new bus cycle starts while the core is calculating.
module snn_param_loader #(
  parameter logic [31:0] PARAM_BASE     = snn_wb_pkg::PARAM_BASE,
  parameter logic [31:0] NEURON_STRIDE  = snn_wb_pkg::NEURON_STRIDE,
  parameter int          CMD_DEPTH      = 4,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  // host command channel
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic                       cmd_we_i,
  input  logic [7:0]                 cmd_neuron_i,
  input  logic [5:0]                 cmd_word_i,
  input  logic [3:0]                 cmd_sel_i,
  input  logic [31:0]                cmd_data_i,
  // core status
  input  logic                       calc_en_i,
  // parameter bus
  snn_param_loader_if.master         wbm,
  output logic                       param_in_en_o,
  // response channel
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [31:0]                rsp_data_o,
  output logic                       rsp_err_o,
  output logic                       busy_o,
  // current FSM state for observation
  output snn_wb_pkg::loader_state_t  dbg_state_o
);
  import snn_wb_pkg::*;

  localparam int CW = $clog2(CMD_DEPTH) + 1;

  // Command and response channels both follow valid/ready: a transfer
  // happens on an edge where valid and ready are both high; the sender holds
  // its payload stable while valid is high and ready is low.

  param_cmd_t    fifo_din;
  param_cmd_t    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          push;
  logic          pop;

  loader_state_t state;
  loader_state_t state_nxt;

  logic [15:0]   tmo_cnt;
  logic          tmo_hit;

  logic          we_q;
  logic [3:0]    sel_q;
  logic [31:0]   adr_q;
  logic [31:0]   dat_q;
  logic [31:0]   rsp_data_q;
  logic          rsp_err_q;

  assign fifo_din = '{we:     cmd_we_i,
                      neuron: cmd_neuron_i,
                      word:   cmd_word_i,
                      sel:    cmd_sel_i,
                      data:   cmd_data_i};

  // Ready is low throughout reset and otherwise tracks the registered fill.
  assign cmd_ready_o = ~fifo_full & ~wb_rst_i;
  assign push        = cmd_valid_i & cmd_ready_o;

  snn_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Abort fires on the edge that completes TIMEOUT_CYCLES cycles in BUS.
  assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  // State register; reset returns to IDLE, dropping cyc/stb at once.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: a pop needs a queued command and an idle core; ack beats timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!fifo_empty && !calc_en_i) begin
          state_nxt = BUS;
        end
      end
      BUS: begin
        if (wbm.wbm_ack_i || tmo_hit) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state register only.
  always_comb begin
    pop           = 1'b0;
    wbm.wbm_cyc_o = 1'b0;
    wbm.wbm_stb_o = 1'b0;
    rsp_valid_o   = 1'b0;
    case (state)
      IDLE: pop = ~fifo_empty & ~calc_en_i;
      BUS: begin
        wbm.wbm_cyc_o = 1'b1;
        wbm.wbm_stb_o = 1'b1;
      end
      RESP:    rsp_valid_o = 1'b1;
      default: pop = 1'b0;
    endcase
    param_in_en_o = wbm.wbm_cyc_o;
    busy_o        = (fifo_count != '0) || (state != IDLE);
  end

  // Bus fields latched at pop so they stay put for the whole cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      we_q  <= 1'b0;
      sel_q <= '0;
      adr_q <= '0;
      dat_q <= '0;
    end else if (pop) begin
      we_q  <= fifo_dout.we;
      sel_q <= fifo_dout.sel;
      adr_q <= param_addr(PARAM_BASE, NEURON_STRIDE,
                          fifo_dout.neuron, fifo_dout.word);
      dat_q <= fifo_dout.data;
    end
  end

  // Ack wait counter: cleared on entry to BUS, advanced each unacked cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tmo_cnt <= '0;
    end else if (pop) begin
      tmo_cnt <= '0;
    end else if (state == BUS && !wbm.wbm_ack_i && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  // Response payload captured on leaving BUS; held through RESP.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if (state == BUS) begin
      if (wbm.wbm_ack_i) begin
        rsp_data_q <= we_q ? 32'h0 : wbm.wbm_dat_i;
        rsp_err_q  <= 1'b0;
      end else if (tmo_hit) begin
        rsp_data_q <= 32'h0;
        rsp_err_q  <= 1'b1;
      end
    end
  end

  assign wbm.wbm_we_o  = we_q;
  assign wbm.wbm_sel_o = sel_q;
  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_dat_o = dat_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_err_o     = rsp_err_q;
  assign dbg_state_o   = state;

endmodule

// File: tb/tb_snn_param_loader.sv
// Directed bench for snn_param_loader with a scoreboard: drivers push the
// expected bus cycle, cycle length and response as they issue commands; a
// monitor pops and compares whenever the DUT shows a bus cycle or response.
module tb_snn_param_loader;
  import snn_wb_pkg::*;

  localparam int          TMO  = 8;
  localparam logic [31:0] MASK = 32'h5A5A_5A5A;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [7:0]    cmd_neuron = '0;
  logic [5:0]    cmd_word = '0;
  logic [3:0]    cmd_sel = '0;
  logic [31:0]   cmd_data = '0;
  logic          calc_en = 1'b0;
  logic          param_in_en;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_data;
  logic          rsp_err;
  logic          busy;
  loader_state_t dbg_state;

  snn_param_loader_if bus ();

  snn_param_loader #(
    .CMD_DEPTH      (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_we_i     (cmd_we),
    .cmd_neuron_i (cmd_neuron),
    .cmd_word_i   (cmd_word),
    .cmd_sel_i    (cmd_sel),
    .cmd_data_i   (cmd_data),
    .calc_en_i    (calc_en),
    .wbm          (bus.master),
    .param_in_en_o(param_in_en),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .rsp_err_o    (rsp_err),
    .busy_o       (busy),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [69:0] exp_bus_q[$];
  int          exp_len_q[$];
  logic [32:0] exp_rsp_q[$];

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_evt(input string name);
    n_checks++;
    $display("FAIL %s: event occurred, none expected", name);
  endtask

  // ---------------- responder ----------------
  logic [31:0] noack_adr = 32'h0;
  int          ack_delay = 1;
  logic        use_ovr   = 1'b0;
  logic [31:0] ovr_data  = 32'h0;
  logic        stray_ack = 1'b0;
  int          rcnt      = 0;
  logic        resp_ack;

  always @(negedge clk) begin
    if (!rst && bus.wbm_cyc_o && bus.wbm_stb_o) begin
      rcnt++;
      resp_ack = (bus.wbm_adr_o != noack_adr) && (rcnt == ack_delay + 1);
    end else begin
      rcnt     = 0;
      resp_ack = 1'b0;
    end
    bus.wbm_ack_i = resp_ack | stray_ack;
    bus.wbm_dat_i = resp_ack ? (use_ovr ? ovr_data : (bus.wbm_adr_o ^ MASK)) : 32'h0;
  end

  // ---------------- monitor ----------------
  logic cyc_prev = 1'b0;
  int   cyc_len  = 0;
  int   en_len   = 0;
  int   cur_len  = -1;
  int   bus_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      cyc_prev = 1'b0;
      cyc_len  = 0;
      en_len   = 0;
      cur_len  = -1;
    end else begin
      if (bus.wbm_cyc_o && !cyc_prev) begin
        bus_seen++;
        cyc_len = 0;
        en_len  = 0;
        if (exp_bus_q.size() == 0) begin
          fail_evt("unexpected_bus_cycle");
          cur_len = -1;
        end else begin
          check("bus_fields", {bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o,
                               bus.wbm_adr_o, bus.wbm_dat_o}, exp_bus_q.pop_front());
          cur_len = exp_len_q.pop_front();
        end
      end
      if (bus.wbm_cyc_o) cyc_len++;
      if (param_in_en) en_len++;
      if (!bus.wbm_cyc_o && cyc_prev && cur_len >= 0) begin
        check("cyc_len", 70'(cyc_len), 70'(cur_len));
        check("param_in_en_len", 70'(en_len), 70'(cur_len));
      end
      cyc_prev = bus.wbm_cyc_o;
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp_q.size() == 0) fail_evt("unexpected_response");
        else check("response", 70'({rsp_err, rsp_data}), 70'(exp_rsp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // mode: 0 = expect nothing, 1 = full transaction, 2 = bus cycle but no response
  task automatic push_cmd(input logic we, input logic [7:0] n, input logic [5:0] w,
                          input logic [3:0] sel, input logic [31:0] d,
                          input logic [31:0] exp_adr, input int exp_len,
                          input logic exp_err, input logic [31:0] exp_data,
                          input int mode);
    int waited;
    waited = 0;
    if (mode != 0) begin
      exp_bus_q.push_back({1'b1, we, sel, exp_adr, d});
      exp_len_q.push_back(exp_len);
    end
    if (mode == 1) exp_rsp_q.push_back({exp_err, exp_data});
    cmd_valid  = 1'b1;
    cmd_we     = we;
    cmd_neuron = n;
    cmd_word   = w;
    cmd_sel    = sel;
    cmd_data   = d;
    @(negedge clk);
    while (!cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      fail_evt("cmd_accept_timeout");
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int waited;
    waited = 0;
    @(negedge clk);
    while ((busy || exp_rsp_q.size() != 0) && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (busy || exp_rsp_q.size() != 0) fail_evt({name, "_drain_timeout"});
    check({name, "_bus_queue_empty"}, 70'(exp_bus_q.size()), 70'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int seen;
    int base_seen;

    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 70'({cmd_ready, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o,
                             rsp_valid, rsp_err, busy, param_in_en, dbg_state}), 70'd0);
    check("reset_data", 70'({bus.wbm_adr_o, bus.wbm_dat_o}), 70'd0);
    check("reset_rsp_data", 70'(rsp_data), 70'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 70'(cmd_ready), 70'd1);
    @(posedge clk);
    #1;

    // Write neuron 3 word 2, ack after two wait cycles.
    ack_delay = 2;
    push_cmd(1'b1, 8'd3, 6'd2, 4'hF, 32'h0000_01FF, 32'h8002_0308, 3, 1'b0, 32'h0, 1);
    wait_idle("write_n3");

    // Read top corner of the map with a fixed return value.
    ack_delay = 1;
    use_ovr   = 1'b1;
    ovr_data  = 32'h1234_5678;
    push_cmd(1'b0, 8'd255, 6'd63, 4'hF, 32'h0, 32'h8002_FFFC, 2, 1'b0, 32'h1234_5678, 1);
    wait_idle("read_n255");
    use_ovr = 1'b0;

    // Stray ack while idle must not create a transaction.
    stray_ack = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 stray_ack = 1'b0;
    repeat (5) @(negedge clk);
    check("stray_ack_busy", 70'(busy), 70'd0);
    @(posedge clk);
    #1;

    // Fill the FIFO while the core calculates, fifth command waits for a pop.
    rsp_ready = 1'b0;
    calc_en   = 1'b1;
    base_seen = bus_seen;
    push_cmd(1'b1, 8'd0,   6'd0,  4'h1, 32'h1111_1111, 32'h8002_0000, 2, 1'b0, 32'h0, 1);
    push_cmd(1'b0, 8'd1,   6'd1,  4'hF, 32'h0,         32'h8002_0104, 2, 1'b0, 32'h8002_0104 ^ MASK, 1);
    push_cmd(1'b1, 8'd128, 6'd5,  4'h3, 32'hCAFE_BABE, 32'h8002_8014, 2, 1'b0, 32'h0, 1);
    push_cmd(1'b0, 8'd7,   6'd32, 4'hF, 32'h0,         32'h8002_0780, 2, 1'b0, 32'h8002_0780 ^ MASK, 1);
    @(negedge clk);
    check("fifo_full_ready", 70'({cmd_ready, bus.wbm_cyc_o}), 70'd0);
    @(posedge clk);
    #1;
    fork
      push_cmd(1'b1, 8'd254, 6'd62, 4'hC, 32'h0BAD_F00D, 32'h8002_FEF8, 2, 1'b0, 32'h0, 1);
      begin
        repeat (3) @(negedge clk);
        check("fifth_blocked", 70'(cmd_ready), 70'd0);
        @(posedge clk);
        #1 calc_en = 1'b0;
      end
    join
    repeat (15) @(negedge clk);
    check("one_cycle_while_rsp_stalled", 70'(bus_seen - base_seen), 70'd1);
    check("rsp_held", 70'({rsp_valid, rsp_err, rsp_data}), 70'({1'b1, 1'b0, 32'h0}));
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_idle("fifo_order");

    // calc_en holds off two queued commands.
    calc_en = 1'b1;
    push_cmd(1'b1, 8'd20, 6'd3, 4'hF, 32'hA5A5_0001, 32'h8002_140C, 2, 1'b0, 32'h0, 1);
    push_cmd(1'b0, 8'd21, 6'd4, 4'hF, 32'h0,         32'h8002_1510, 2, 1'b0, 32'h8002_1510 ^ MASK, 1);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.wbm_cyc_o) seen++;
    end
    check("calc_hold_no_cyc", 70'(seen), 70'd0);
    @(posedge clk);
    #1 calc_en = 1'b0;
    @(negedge clk);
    check("calc_fall_cyc_low", 70'(bus.wbm_cyc_o), 70'd0);
    @(negedge clk);
    check("calc_fall_cyc_next", 70'(bus.wbm_cyc_o), 70'd1);
    wait_idle("calc_hold");

    // Timeout abort, then a normal command behind it.
    noack_adr = 32'h8002_0A00;
    push_cmd(1'b0, 8'd10, 6'd0, 4'hF, 32'h0,         32'h8002_0A00, TMO, 1'b1, 32'h0, 1);
    ack_delay = 2;
    push_cmd(1'b1, 8'd11, 6'd1, 4'h5, 32'h55AA_55AA, 32'h8002_0B04, 3,   1'b0, 32'h0, 1);
    wait_idle("timeout");

    // Ack on the timeout cycle itself wins.
    ack_delay = TMO - 1;
    push_cmd(1'b0, 8'd12, 6'd2, 4'hF, 32'h0, 32'h8002_0C08, TMO, 1'b0, 32'h8002_0C08 ^ MASK, 1);
    wait_idle("ack_at_timeout");

    // Reset in the middle of a bus cycle with another command queued.
    noack_adr = 32'h8002_0D00;
    push_cmd(1'b0, 8'd13, 6'd0, 4'hF, 32'h0,         32'h8002_0D00, TMO, 1'b0, 32'h0, 2);
    push_cmd(1'b1, 8'd14, 6'd1, 4'hF, 32'h7777_7777, 32'h0,         0,   1'b0, 32'h0, 0);
    seen = 0;
    while (!bus.wbm_cyc_o && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    check("cyc_before_reset", 70'(bus.wbm_cyc_o), 70'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("reset_drops_cyc", 70'({bus.wbm_cyc_o, bus.wbm_stb_o, param_in_en}), 70'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    noack_adr = 32'h0;
    base_seen = bus_seen;
    @(negedge clk);
    check("after_reset_idle", 70'({busy, cmd_ready, dbg_state}), 70'({1'b0, 1'b1, 2'd0}));
    repeat (20) @(negedge clk);
    check("after_reset_no_bus", 70'(bus_seen - base_seen), 70'd0);
    check("after_reset_no_rsp", 70'(rsp_valid), 70'd0);

    check("final_rsp_queue_empty", 70'(exp_rsp_q.size()), 70'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/snn_param_loader.md
# snn_param_loader

Wishbone initiator that loads neuron parameters into a 256-neuron core's parameter space. It accepts a buffered stream of write/read commands that address parameters by neuron index and word. Each command becomes one single-beat Wishbone classic cycle, gated by the core's `param_in_en` qualifier. Results return on a response channel. It sits between the host/config sequencer and the core's Wishbone responder, and holds off while the core is calculating.

## Interface
Parameters:
- `PARAM_BASE`, 32'h80020000, base address of the parameter region.
- `NEURON_STRIDE`, 32'h00000100, address stride per neuron.
- `CMD_DEPTH`, 4, command FIFO depth (power of two, ≥2).
- `TIMEOUT_CYCLES`, 255, maximum cycles waiting for ack before abort (1..65535).

Ports:
- `wb_clk_i` in 1: clock.
- `wb_rst_i` in 1: reset. One clock; reset is asynchronous and active-high.
- `cmd_valid_i` in 1: command valid.
- `cmd_ready_o` out 1: command FIFO not full.
- `cmd_we_i` in 1: 1 = write, 0 = read.
- `cmd_neuron_i` in 8: neuron index 0..255.
- `cmd_word_i` in 6: 32-bit word offset within the neuron's 256-byte window.
- `cmd_sel_i` in 4: byte lanes.
- `cmd_data_i` in 32: write data.
- `calc_en_i` in 1: core calculating; no new bus cycle may start while high.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` out 1: Wishbone master controls.
- `wbm_sel_o` out 4; `wbm_adr_o` out 32; `wbm_dat_o` out 32.
- `wbm_ack_i` in 1; `wbm_dat_i` in 32.
- `param_in_en_o` out 1: equals `wbm_cyc_o`; qualifies the core's parameter port.
- `rsp_valid_o` out 1; `rsp_ready_i` in 1.
- `rsp_data_o` out 32: read data; 0 for writes.
- `rsp_err_o` out 1: timeout abort.
- `busy_o` out 1: FIFO non-empty or FSM not IDLE.

## Operation
- Address: `PARAM_BASE + cmd_neuron_i*NEURON_STRIDE + {cmd_word_i,2'b00}`, computed in 32 bits with wrap-around modulo 2^32.
- Commands are pushed into the FIFO on `cmd_valid_i & cmd_ready_o`. The FIFO is strict in order.
- FSM:
  - IDLE: if the FIFO is non-empty and `calc_en_i`=0, pop the head, register the bus outputs, and go to BUS.
  - BUS: `cyc`/`stb` are held with stable address, data, sel and we. On `wbm_ack_i`, capture `wbm_dat_i` (reads) and go to RESP. When the timeout counter reaches `TIMEOUT_CYCLES`, go to RESP with err=1 and data=0.
  - RESP: `rsp_valid_o`=1 with stable data and err. On `rsp_ready_i`, go to IDLE.
- `calc_en_i` rising during BUS or RESP does not abort the transaction in progress; it only blocks the next pop.
- FIFO full: `cmd_ready_o`=0. `cmd_ready_o` is derived from the registered count only, so there is no push while full even if a pop occurs in the same cycle.
- FIFO empty with `cmd_valid_i` high: the command is pushed and becomes poppable the following cycle. There is no bypass.

## Timing
- Reset values: all outputs 0 except `cmd_ready_o`, which is 0 while `wb_rst_i` is high and 1 from the first cycle after release. Reset also flushes the FIFO and puts the FSM in IDLE.
- Reset mid-transaction: `wbm_cyc_o`/`wbm_stb_o` drop asynchronously, no response is produced, and queued commands are lost.
- Command accepted at edge N: `wbm_cyc_o` goes high from cycle N+2 if `calc_en_i`=0 at N+1. Otherwise the first cycle after `calc_en_i` is seen low, plus one.
- Ack sampled high at edge M: `cyc`/`stb` are low and `rsp_valid_o` is high from M+1. Minimum one idle bus cycle separates transactions.
- With `rsp_ready_i` held at 1, back-to-back commands reach a throughput of one transaction per 3 cycles plus responder latency.
- Timeout: the counter clears on entering BUS. Abort occurs when the cycle count in BUS equals `TIMEOUT_CYCLES` without ack. An ack arriving in that same cycle wins (err=0).
- `wbm_ack_i` outside BUS is ignored.

## Structure
- Shared package `snn_wb_pkg`:
  - `PARAM_BASE` / `NEURON_STRIDE` constants.
  - `param_cmd_t` struct {we, neuron[7:0], word[5:0], sel[3:0], data[31:0]}.
  - FSM state enum {IDLE, BUS, RESP}.
- Sub-module `snn_cmd_fifo`: synchronous FIFO of `param_cmd_t`, `CMD_DEPTH` entries, with full/empty flags and a registered count.

## Test plan
- Write neuron 3, word 2, data 32'h0000_01FF, responder acks after 2 cycles -> `wbm_adr_o`=32'h8002_0308, `wbm_we_o`=1, `param_in_en_o`=1 for 3 cycles; one response with data 0, err 0.
- Read neuron 255, word 63, responder returns 32'h1234_5678 -> `wbm_adr_o`=32'h8002_FFFC; `rsp_data_o`=32'h1234_5678.
- Push 5 commands with `rsp_ready_i`=0 -> `cmd_ready_o` drops after the FIFO fills with 4 entries (a 5th entry is absorbed only once the head pops); bus cycles are issued in push order; responses drain in order once `rsp_ready_i`=1.
- Hold `calc_en_i`=1 with 2 commands queued for 10 cycles -> `wbm_cyc_o` stays 0; first `cyc` appears 1 cycle after `calc_en_i` falls.
- Responder never acks, `TIMEOUT_CYCLES`=8 -> `cyc` high exactly 8 cycles, then response with err=1, data 0; the next queued command proceeds normally.
- Assert `wb_rst_i` mid-BUS -> `wbm_cyc_o` low immediately; after release, FIFO empty, `busy_o`=0, no response emitted.
